// File: rtl/riscv_pkg.sv
// Shared types for the fetch stage: PC source encoding, fetch FSM states and
// the default reset vector.
package riscv_pkg;

  typedef enum logic [1:0] {
    PCSRC_PLUS4  = 2'b00,
    PCSRC_JUMP   = 2'b01,
    PCSRC_BRANCH = 2'b10,
    PCSRC_JALR   = 2'b11
  } pc_src_t;

  typedef enum logic [1:0] {
    BOOT  = 2'b00,
    FETCH = 2'b01,
    DRAIN = 2'b10
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/branch_resolve.sv
// Combinational redirect decode: decides whether EX redirects fetch, picks the
// word-aligned target and flags targets whose low two bits were not zero.
module branch_resolve
  import riscv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       PCSrcE,
  input  logic             ZeroE,
  input  logic [WIDTH-1:0] PCTargetE,
  input  logic [WIDTH-1:0] ALUResultE,
  output logic             taken,
  output logic [WIDTH-1:0] target,
  output logic             misaligned
);

  logic [WIDTH-1:0] raw_target;

  // Select redirect condition and raw target from the PC source encoding.
  always_comb begin
    taken      = 1'b0;
    raw_target = PCTargetE;
    case (pc_src_t'(PCSrcE))
      PCSRC_JUMP:   taken = 1'b1;
      PCSRC_BRANCH: taken = ZeroE;
      PCSRC_JALR: begin
        taken      = 1'b1;
        raw_target = ALUResultE & ~WIDTH'(1);
      end
      default:      taken = 1'b0;
    endcase
  end

  // Fetch addresses are word aligned; force the low bits and report if they mattered.
  always_comb begin
    target     = {raw_target[WIDTH-1:2], 2'b00};
    misaligned = (raw_target[1:0] != 2'b00);
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns PCF, runs the imem request/ready handshake,
// flushes D/E on redirects and drains an outstanding fetch before re-steering.
module fetch_ctrl
  import riscv_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = WIDTH'(RESET_PC_DEFAULT),
  parameter int               CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 StallF,
  input  logic [1:0]           PCSrcE,
  input  logic                 ZeroE,
  input  logic [WIDTH-1:0]     PCTargetE,
  input  logic [WIDTH-1:0]     ALUResultE,
  input  logic                 imem_ready,
  output logic                 imem_req,
  output logic [WIDTH-1:0]     PCF,
  output logic [WIDTH-1:0]     PCPlus4F,
  output logic                 InstrValidF,
  output logic                 FlushD,
  output logic                 FlushE,
  output logic                 TakenE,
  output logic                 misaligned,
  output logic [CNT_WIDTH-1:0] redirect_count
);

  fetch_state_t     state, state_next;
  logic [WIDTH-1:0] pc, pc_next;
  logic [WIDTH-1:0] pending, pending_next;
  logic [CNT_WIDTH-1:0] cnt;
  logic             taken;
  logic [WIDTH-1:0] target;
  logic             target_misaligned;

  branch_resolve #(.WIDTH(WIDTH)) u_resolve (
    .PCSrcE     (PCSrcE),
    .ZeroE      (ZeroE),
    .PCTargetE  (PCTargetE),
    .ALUResultE (ALUResultE),
    .taken      (taken),
    .target     (target),
    .misaligned (target_misaligned)
  );

  assign PCF            = pc;
  assign PCPlus4F       = pc + WIDTH'(4);
  assign misaligned     = TakenE & target_misaligned;
  assign redirect_count = cnt;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= BOOT;
    else     state <= state_next;
  end

  // PC and pending-redirect registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= RESET_PC;
      pending <= '0;
    end else begin
      pc      <= pc_next;
      pending <= pending_next;
    end
  end

  // Saturating count of accepted redirects.
  always_ff @(posedge clk) begin
    if (rst)                       cnt <= '0;
    else if (TakenE && cnt != '1)  cnt <= cnt + CNT_WIDTH'(1);
  end

  // Next-state, next-PC and handshake/flush outputs. A redirect always wins
  // over StallF; while a request is outstanding PCF is never changed.
  always_comb begin
    state_next   = state;
    pc_next      = pc;
    pending_next = pending;
    imem_req     = 1'b0;
    InstrValidF  = 1'b0;
    FlushD       = 1'b0;
    FlushE       = 1'b0;
    TakenE       = 1'b0;
    case (state)
      BOOT: begin
        FlushD     = 1'b1;
        FlushE     = 1'b1;
        state_next = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (taken) begin
          TakenE = 1'b1;
          FlushD = 1'b1;
          FlushE = 1'b1;
          if (imem_ready) begin
            pc_next = target;
          end else begin
            pending_next = target;
            state_next   = DRAIN;
          end
        end else if (imem_ready) begin
          InstrValidF = 1'b1;
          if (!StallF) pc_next = PCPlus4F;
        end
      end
      DRAIN: begin
        imem_req = 1'b1;
        if (taken) begin
          TakenE       = 1'b1;
          FlushD       = 1'b1;
          FlushE       = 1'b1;
          pending_next = target;
        end
        if (imem_ready) begin
          pc_next    = taken ? target : pending;
          state_next = FETCH;
        end
      end
      default: state_next = BOOT;
    endcase
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        StallF;
  logic [1:0]  PCSrcE;
  logic        ZeroE;
  logic [31:0] PCTargetE;
  logic [31:0] ALUResultE;
  logic        imem_ready;
  logic        imem_req;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;
  logic        InstrValidF;
  logic        FlushD;
  logic        FlushE;
  logic        TakenE;
  logic        misaligned;
  logic [2:0]  redirect_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_ctrl #(.WIDTH(32), .RESET_PC(32'h0000_0000), .CNT_WIDTH(3)) dut (
    .clk            (clk),
    .rst            (rst),
    .StallF         (StallF),
    .PCSrcE         (PCSrcE),
    .ZeroE          (ZeroE),
    .PCTargetE      (PCTargetE),
    .ALUResultE     (ALUResultE),
    .imem_ready     (imem_ready),
    .imem_req       (imem_req),
    .PCF            (PCF),
    .PCPlus4F       (PCPlus4F),
    .InstrValidF    (InstrValidF),
    .FlushD         (FlushD),
    .FlushE         (FlushE),
    .TakenE         (TakenE),
    .misaligned     (misaligned),
    .redirect_count (redirect_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; StallF = 1'b0; PCSrcE = 2'b00; ZeroE = 1'b0;
    PCTargetE = '0; ALUResultE = '0; imem_ready = 1'b1;
    tick(); tick();
    rst = 1'b0; #1;
    chk("boot_req",    32'(imem_req), 32'd0);
    chk("boot_flushd", 32'(FlushD), 32'd1);
    chk("boot_flushe", 32'(FlushE), 32'd1);
    chk("boot_valid",  32'(InstrValidF), 32'd0);
    chk("boot_pc",     PCF, 32'h0);
    chk("boot_cnt",    32'(redirect_count), 32'd0);

    tick();
    chk("seq_pc0",    PCF, 32'h0);
    chk("seq_valid0", 32'(InstrValidF), 32'd1);
    chk("seq_req0",   32'(imem_req), 32'd1);
    chk("seq_plus4",  PCPlus4F, 32'h4);
    chk("seq_flush0", 32'(FlushD), 32'd0);
    tick(); chk("seq_pc4", PCF, 32'h4);
    tick(); chk("seq_pc8", PCF, 32'h8);

    // Taken conditional branch
    tick(); PCSrcE = 2'b10; ZeroE = 1'b1; PCTargetE = 32'h40; #1;
    chk("br_pc12",  PCF, 32'hC);
    chk("br_flushd", 32'(FlushD), 32'd1);
    chk("br_flushe", 32'(FlushE), 32'd1);
    chk("br_taken",  32'(TakenE), 32'd1);
    chk("br_valid",  32'(InstrValidF), 32'd0);
    tick(); PCSrcE = 2'b00; #1;
    chk("br_target", PCF, 32'h40);
    chk("br_cnt",    32'(redirect_count), 32'd1);
    chk("br_noflush", 32'(FlushD), 32'd0);

    // Not-taken branch
    PCSrcE = 2'b10; ZeroE = 1'b0; #1;
    chk("nt_taken", 32'(TakenE), 32'd0);
    chk("nt_flush", 32'(FlushE), 32'd0);
    chk("nt_valid", 32'(InstrValidF), 32'd1);

    // JALR with misaligned target
    tick(); PCSrcE = 2'b11; ALUResultE = 32'h103; #1;
    chk("nt_seq",    PCF, 32'h44);
    chk("jalr_mis",  32'(misaligned), 32'd1);
    chk("jalr_taken", 32'(TakenE), 32'd1);
    tick(); PCSrcE = 2'b00; #1;
    chk("jalr_pc",   PCF, 32'h100);
    chk("jalr_mis0", 32'(misaligned), 32'd0);
    chk("jalr_cnt",  32'(redirect_count), 32'd2);

    // Jump while imem not ready -> drain
    imem_ready = 1'b0; PCSrcE = 2'b01; PCTargetE = 32'h80; #1;
    chk("dr_flush", 32'(FlushD), 32'd1);
    chk("dr_valid", 32'(InstrValidF), 32'd0);
    tick(); PCSrcE = 2'b00; #1;
    chk("dr1_pc",    PCF, 32'h100);
    chk("dr1_req",   32'(imem_req), 32'd1);
    chk("dr1_flush", 32'(FlushD), 32'd0);
    chk("dr1_valid", 32'(InstrValidF), 32'd0);
    tick();
    chk("dr2_pc", PCF, 32'h100);
    tick(); imem_ready = 1'b1; #1;
    chk("dr3_pc",    PCF, 32'h100);
    chk("dr3_valid", 32'(InstrValidF), 32'd0);
    chk("dr3_cnt",   32'(redirect_count), 32'd3);
    tick();
    chk("dr_target", PCF, 32'h80);
    chk("dr_valid2", 32'(InstrValidF), 32'd1);

    // Redirect beats stall, then stall alone holds
    StallF = 1'b1; PCSrcE = 2'b01; PCTargetE = 32'h200; #1;
    chk("st_taken", 32'(TakenE), 32'd1);
    tick(); PCSrcE = 2'b00; #1;
    chk("st_pc",    PCF, 32'h200);
    chk("st_cnt",   32'(redirect_count), 32'd4);
    chk("st_req",   32'(imem_req), 32'd1);
    chk("st_valid", 32'(InstrValidF), 32'd1);
    tick();
    chk("st_hold", PCF, 32'h200);
    StallF = 1'b0;

    // Second redirect during drain overwrites pending
    imem_ready = 1'b0; PCSrcE = 2'b01; PCTargetE = 32'h300;
    tick(); PCTargetE = 32'h400; #1;
    chk("dd_pc",    PCF, 32'h200);
    chk("dd_flush", 32'(FlushD), 32'd1);
    chk("dd_taken", 32'(TakenE), 32'd1);
    tick(); PCSrcE = 2'b00; imem_ready = 1'b1; #1;
    chk("dd_pc2", PCF, 32'h200);
    chk("dd_cnt", 32'(redirect_count), 32'd6);
    tick();
    chk("dd_target", PCF, 32'h400);
    chk("dd_plus4",  PCPlus4F, 32'h404);

    // PC+4 wrap
    PCSrcE = 2'b01; PCTargetE = 32'hFFFF_FFFC;
    tick(); PCSrcE = 2'b00; #1;
    chk("wr_pc",    PCF, 32'hFFFF_FFFC);
    chk("wr_plus4", PCPlus4F, 32'h0);
    chk("wr_cnt",   32'(redirect_count), 32'd7);
    tick();
    chk("wr_seq", PCF, 32'h0);

    // Saturation, then reset in DRAIN
    imem_ready = 1'b0; PCSrcE = 2'b01; PCTargetE = 32'h500;
    tick(); PCSrcE = 2'b00; #1;
    chk("sat_cnt", 32'(redirect_count), 32'd7);
    chk("sat_pc",  PCF, 32'h0);
    rst = 1'b1;
    tick(); rst = 1'b0; imem_ready = 1'b1; PCSrcE = 2'b01; PCTargetE = 32'h600; #1;
    chk("rs_pc",    PCF, 32'h0);
    chk("rs_cnt",   32'(redirect_count), 32'd0);
    chk("rs_req",   32'(imem_req), 32'd0);
    chk("rs_flush", 32'(FlushE), 32'd1);
    chk("rs_taken", 32'(TakenE), 32'd0);
    tick(); PCSrcE = 2'b00; #1;
    chk("rs_pc2",  PCF, 32'h0);
    chk("rs_cnt2", 32'(redirect_count), 32'd0);
    chk("rs_req2", 32'(imem_req), 32'd1);
    tick();
    chk("rs_pc3", PCF, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
